// File: rtl/regfile_pkg.sv
// Shared defaults and types for the datapath register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/param_reg_file_if.sv
// Write/read bus of the register file: writeback drives the write side, decode drives read addresses.
interface param_reg_file_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
);

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [DATA_W-1:0]   rd_data_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_b;
  logic [NUM_REGS-1:0] wr_onehot;
  logic                wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_onehot, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_onehot, wr_err
  );

endinterface

// File: rtl/param_reg_file_wr_addr_decoder.sv
// Combinational one-hot write decoder with enable and out-of-range detection.
module wr_addr_decoder #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot,
  output logic                out_of_range
);

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (addr == ADDR_W'(i));
    end
    if (ZERO_REG) begin
      onehot[0] = 1'b0;
    end
  end

  assign out_of_range = en && ({1'b0, addr} >= NUM_REGS_EXT);

endmodule

// File: rtl/param_reg_file.sv
// Parametrised register file with two combinational read ports and a registered write monitor.
// Optional write-through forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module param_reg_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input logic             clk,
  input logic             rst,
  param_reg_file_if.slave bus
);

  logic [NUM_REGS-1:0] wr_onehot_next;
  logic                wr_oor;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_onehot_q, wr_onehot_d;
  logic                wr_err_q, wr_err_d;

  logic [ADDR_W-1:0]   rd_addr [2];
  logic [DATA_W-1:0]   rd_data [2];

  wr_addr_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_dec (
    .en           (bus.wr_en),
    .addr         (bus.wr_addr),
    .onehot       (wr_onehot_next),
    .out_of_range (wr_oor)
  );

  // A zero one-hot vector (disabled, out of range or reg 0) leaves storage untouched.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_onehot_next[i]) begin
        regs_d[i] = bus.wr_data;
      end
    end
    wr_onehot_d = wr_onehot_next;
    wr_err_d    = wr_oor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_onehot_q <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      wr_onehot_q <= wr_onehot_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;

  // Unmatched addresses (>= NUM_REGS) fall through to zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if ((rd_addr[p] == ADDR_W'(i)) && !(ZERO_REG && (i == 0))) begin
          rd_data[p] = regs_q[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if ((|wr_onehot_next) && (bus.wr_addr == rd_addr[p])) begin
        rd_data[p] = bus.wr_data;
      end
`endif
    end
  end

  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];
  assign bus.wr_onehot = wr_onehot_q;
  assign bus.wr_err    = wr_err_q;

endmodule
